// File: rtl/interconnect_link_buffer_if.sv
// Ready/valid message channel for interconnect_link_buffer.
// The slave modport is the buffer side; the master modport drives messages in and accepts them out.
interface interconnect_link_buffer_if #(
  parameter int WIDTH = 128
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/interconnect_link_buffer.sv
// In-order link hop: each message is held at least LATENCY cycles; remote status is delayed by the same LATENCY.
// Optional delivery/stall counters are enabled by defining INTERCONNECT_LINK_STATS_EN.
module interconnect_link_buffer #(
  parameter int WIDTH   = 128,
  parameter int DEPTH   = 8,
  parameter int LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  interconnect_link_buffer_if.slave link,
  input  logic                   remote_has_message_flying,
  input  logic                   remote_has_odd_clusters,
  output logic                   has_message_flying,
  output logic                   has_odd_clusters,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [31:0]            stat_msg_count,
  output logic [31:0]            stat_stall_cycles
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(LATENCY + 1);

  typedef logic [GW-1:0] age_t;
  localparam age_t AGE_MAX = age_t'(LATENCY);

  function automatic age_t age_sat_inc(input age_t a);
    return (a == AGE_MAX) ? a : a + age_t'(1);
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  age_t             age_q [DEPTH];
  age_t             age_d [DEPTH];
  logic [1:0]       status_q [LATENCY];
  logic             push, pop;

  // No pass-through when full: a pop in the same cycle does not reopen in_ready.
  assign link.in_ready  = reset && (count_q < CW'(DEPTH));
  assign link.out_valid = (count_q != '0) && (age_q[rd_ptr_q] == AGE_MAX);
  assign link.out_data  = mem_q[rd_ptr_q];
  assign push           = link.in_valid && link.in_ready;
  assign pop            = link.out_valid && link.out_ready;

  assign occupancy          = count_q;
  assign has_odd_clusters   = status_q[LATENCY-1][0];
  assign has_message_flying = status_q[LATENCY-1][1] | (count_q != '0) | link.in_valid;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // An entry is occupied when its distance from the read pointer is below count.
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = age_q[i];
      if (pop && (AW'(i) == rd_ptr_q))
        age_d[i] = '0;
      else if ({1'b0, AW'(i) - rd_ptr_q} < count_q)
        age_d[i] = age_sat_inc(age_q[i]);
      if (push && (AW'(i) == wr_ptr_q))
        age_d[i] = age_t'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
      // Status reads "busy" until real remote status has crossed the link.
      for (int s = 0; s < LATENCY; s++) status_q[s] <= 2'b11;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
      status_q[0] <= {remote_has_message_flying, remote_has_odd_clusters};
      for (int s = 1; s < LATENCY; s++) status_q[s] <= status_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= link.in_data;
  end

`ifdef INTERCONNECT_LINK_STATS_EN
  logic [31:0] msg_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop) msg_cnt_q <= msg_cnt_q + 32'd1;
      if (link.out_valid && !link.out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stat_msg_count    = msg_cnt_q;
  assign stat_stall_cycles = stall_cnt_q;
`else
  assign stat_msg_count    = '0;
  assign stat_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_interconnect_link_buffer.sv
// Directed bench for interconnect_link_buffer (LATENCY=3, DEPTH=8) with a queue-based delivery scoreboard.
module tb_interconnect_link_buffer;
  localparam int WIDTH   = 128;
  localparam int DEPTH   = 8;
  localparam int LATENCY = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rf = 1'b0;
  logic        ro = 1'b0;
  logic        flying, odd;
  logic [3:0]  occ;
  logic [31:0] st_msg, st_stall;

  interconnect_link_buffer_if #(.WIDTH(WIDTH)) lnk ();

  interconnect_link_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .link                      (lnk),
    .remote_has_message_flying (rf),
    .remote_has_odd_clusters   (ro),
    .has_message_flying        (flying),
    .has_odd_clusters          (odd),
    .occupancy                 (occ),
    .stat_msg_count            (st_msg),
    .stat_stall_cycles         (st_stall)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               earliest;
  } exp_t;
  exp_t expq[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: record an accepted push into the scoreboard, then settle just after the edge.
  task automatic cycle();
    @(negedge clk);
    if (reset && lnk.in_valid && lnk.in_ready)
      expq.push_back('{data: lnk.in_data, earliest: cyc + LATENCY});
    @(posedge clk);
    #1;
  endtask

  // Delivery monitor: every pop must match the oldest outstanding push and respect latency.
  always @(negedge clk) begin
    exp_t e;
    if (reset && lnk.out_valid && lnk.out_ready) begin
      if (expq.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_delivery: got %0h expected no message", lnk.out_data);
      end else begin
        e = expq.pop_front();
        chk("delivery_order", lnk.out_data, e.data);
        chk("delivery_latency", 128'(cyc >= e.earliest), 128'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    lnk.in_valid  = 1'b0;
    lnk.in_data   = '0;
    lnk.out_ready = 1'b0;

    // Reset held
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", lnk.in_ready, 0);
    chk("rst_out_valid", lnk.out_valid, 0);
    chk("rst_occupancy", occ, 0);
    chk("rst_flying", flying, 1);
    chk("rst_odd", odd, 1);
    chk("rst_stat_msg", st_msg, 0);
    chk("rst_stat_stall", st_stall, 0);

    // Release: status stays busy for LATENCY cycles
    reset = 1'b1;
    #1;
    chk("rel_in_ready", lnk.in_ready, 1);
    chk("rel_flying_0", flying, 1);
    chk("rel_odd_0", odd, 1);
    for (int k = 1; k <= 3; k++) begin
      cycle();
      chk("rel_flying", flying, (k < 3) ? 1 : 0);
      chk("rel_odd", odd, (k < 3) ? 1 : 0);
    end

    // Single message latency
    lnk.out_ready = 1'b1;
    lnk.in_data   = 128'h1;
    lnk.in_valid  = 1'b1;
    #1;
    chk("lat_flying_invalid", flying, 1);
    cycle();
    lnk.in_valid = 1'b0;
    #1;
    chk("lat_valid_c1", lnk.out_valid, 0);
    chk("lat_flying_c1", flying, 1);
    cycle();
    chk("lat_valid_c2", lnk.out_valid, 0);
    cycle();
    chk("lat_valid_c3", lnk.out_valid, 1);
    chk("lat_data_c3", lnk.out_data, 128'h1);
    chk("lat_flying_c3", flying, 1);
    cycle();
    chk("lat_valid_after_pop", lnk.out_valid, 0);
    chk("lat_occ_after_pop", occ, 0);
    chk("lat_flying_after_pop", flying, 0);

    // Burst fill, rejected 9th push, drain in order
    lnk.out_ready = 1'b0;
    lnk.in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      lnk.in_data = 128'(16 + i);
      cycle();
    end
    chk("burst_occ_full", occ, 8);
    chk("burst_in_ready_full", lnk.in_ready, 0);
    lnk.in_data = 128'hFF;
    cycle();
    chk("burst_9th_rejected", occ, 8);
    chk("burst_head_held", lnk.out_valid, 1);
    chk("burst_head_data", lnk.out_data, 128'd16);
    lnk.in_valid  = 1'b0;
    lnk.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("burst_drain_occ", occ, 128'(7 - i));
      chk("burst_drain_valid", lnk.out_valid, (i < 7) ? 1 : 0);
    end

    // Full buffer with simultaneous pop and push attempt
    lnk.out_ready = 1'b0;
    lnk.in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      lnk.in_data = 128'(32 + i);
      cycle();
    end
    lnk.in_data   = 128'hAA;
    lnk.out_ready = 1'b1;
    cycle();
    chk("full_pop_no_push_occ", occ, 7);
    chk("full_pop_ready_next", lnk.in_ready, 1);
    lnk.out_ready = 1'b0;
    cycle();
    chk("push_after_full_pop_occ", occ, 8);
    lnk.in_valid  = 1'b0;
    lnk.out_ready = 1'b1;
    repeat (10) cycle();
    chk("full_drain_occ", occ, 0);

    // Status pipeline: step and one-cycle pulses
    ro = 1'b1;
    cycle();
    chk("odd_rise_c1", odd, 0);
    cycle();
    chk("odd_rise_c2", odd, 0);
    cycle();
    chk("odd_rise_c3", odd, 1);
    ro = 1'b0;
    repeat (3) cycle();
    chk("odd_fall", odd, 0);
    ro = 1'b1;
    cycle();
    ro = 1'b0;
    cnt = 0;
    repeat (6) begin
      cycle();
      if (odd) cnt++;
    end
    chk("odd_pulse_width", 128'(cnt), 1);
    rf = 1'b1;
    cycle();
    rf = 1'b0;
    cnt = 0;
    repeat (6) begin
      cycle();
      if (flying) cnt++;
    end
    chk("flying_pulse_width", 128'(cnt), 1);

    // Reset mid-operation with 5 buffered messages
    lnk.out_ready = 1'b0;
    lnk.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lnk.in_data = 128'(48 + i);
      cycle();
    end
    lnk.in_valid = 1'b0;
    repeat (2) cycle();
    chk("mid_occ5", occ, 5);
    chk("mid_valid_before_rst", lnk.out_valid, 1);
    reset = 1'b0;
    expq.delete();
    #1;
    chk("mid_rst_occ", occ, 0);
    chk("mid_rst_valid", lnk.out_valid, 0);
    chk("mid_rst_in_ready", lnk.in_ready, 0);
    chk("mid_rst_flying", flying, 1);
    chk("mid_rst_odd", odd, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    lnk.out_ready = 1'b1;
    #1;
    chk("mid_rel_in_ready", lnk.in_ready, 1);
    for (int k = 1; k <= 4; k++) begin
      cycle();
      chk("mid_rel_flying", flying, (k < 3) ? 1 : 0);
      chk("mid_rel_odd", odd, (k < 3) ? 1 : 0);
      chk("mid_rel_no_delivery", lnk.out_valid, 0);
    end

    // Statistics: 4 deliveries and 6 stalled cycles starting from reset
    reset = 1'b0;
    expq.delete();
    #10;
    reset = 1'b1;
    lnk.out_ready = 1'b0;
    lnk.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lnk.in_data = 128'(64 + i);
      cycle();
    end
    lnk.in_valid = 1'b0;
    repeat (5) cycle();
    lnk.out_ready = 1'b1;
    repeat (4) cycle();
    lnk.out_ready = 1'b0;
    chk("stats_occ", occ, 0);
`ifdef INTERCONNECT_LINK_STATS_EN
    chk("stat_msg_count", st_msg, 4);
    chk("stat_stall_cycles", st_stall, 6);
`else
    chk("stat_msg_count_off", st_msg, 0);
    chk("stat_stall_cycles_off", st_stall, 0);
`endif

    repeat (2) cycle();
    chk("scoreboard_drained", 128'(expq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
